// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Optional grant statistics are enabled with DMEM_ARB_STATS_EN.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int STATS_W    = 16;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker; ptr = 0 favours req[0].
// Purely combinational, one-hot grant.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       any
);

  always_comb begin
    grant    = 2'b00;
    grant[0] = req[0] & (~req[1] | ~ptr);
    grant[1] = req[1] & (~req[0] |  ptr);
  end

  assign any = |req;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer in front of the single-ported data memory.
// Define DMEM_ARB_STATS_EN to add saturating per-requester grant counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_memread,
  output logic              m_memwrite,
  input  logic [DATA_W-1:0] m_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0] grant_cnt0,
  output logic [STATS_W-1:0] grant_cnt1
`endif
);

  state_t            state;
  state_t            next;
  logic              ptr;
  logic              owner;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [1:0]        pick;
  logic              any;
  logic              take;
  logic              active;

  rr_pick2 u_pick (
    .req   ({r1_req, r0_req}),
    .ptr   (ptr),
    .grant (pick),
    .any   (any)
  );

  assign take   = (state == IDLE) & any & ~reset;
  assign r0_gnt = take & pick[0];
  assign r1_gnt = take & pick[1];

  // Memory pins are forced idle during reset so an abandoned write stops at once.
  assign active     = (state == ACCESS) & ~reset;
  assign m_address  = active ? req_addr  : '0;
  assign m_wdata    = active ? req_wdata : '0;
  assign m_memread  = active & ~req_we;
  assign m_memwrite = active &  req_we;

  always_comb begin
    next = state;
    unique case (state)
      IDLE:   if (any) next = ACCESS;
      ACCESS: next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      owner     <= 1'b0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
    end else begin
      state     <= next;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      if (take) begin
        owner     <= pick[1];
        req_we    <= pick[1] ? r1_we    : r0_we;
        req_addr  <= pick[1] ? r1_addr  : r0_addr;
        req_wdata <= pick[1] ? r1_wdata : r0_wdata;
      end
      if (state == ACCESS) begin
        ptr <= ~owner;
        if (owner) begin
          r1_rvalid <= 1'b1;
          r1_rdata  <= req_we ? '0 : m_rdata;
        end else begin
          r0_rvalid <= 1'b1;
          r0_rdata  <= req_we ? '0 : m_rdata;
        end
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (r0_gnt && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (r1_gnt && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-indexed memory model.
// Grant-counter checks compile only with DMEM_ARB_STATS_EN.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [31:0] r0_rdata, r1_rdata;
  logic [31:0] m_address, m_wdata, m_rdata;
  logic        m_memread, m_memwrite;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  int total = 0;
  int passed = 0;

  logic [31:0] mem [64];

  always #5 clock = ~clock;

  // Memory reloads while reset is high; otherwise commits writes on negedge.
  always @(negedge clock) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + i;
    end else if (m_memwrite) begin
      mem[m_address[7:2]] <= m_wdata;
    end
  end

  assign m_rdata = mem[m_address[7:2]];

  dmem_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .r0_req     (r0_req),
    .r0_we      (r0_we),
    .r0_addr    (r0_addr),
    .r0_wdata   (r0_wdata),
    .r0_gnt     (r0_gnt),
    .r0_rvalid  (r0_rvalid),
    .r0_rdata   (r0_rdata),
    .r1_req     (r1_req),
    .r1_we      (r1_we),
    .r1_addr    (r1_addr),
    .r1_wdata   (r1_wdata),
    .r1_gnt     (r1_gnt),
    .r1_rvalid  (r1_rvalid),
    .r1_rdata   (r1_rdata),
    .m_address  (m_address),
    .m_wdata    (m_wdata),
    .m_memread  (m_memread),
    .m_memwrite (m_memwrite),
    .m_rdata    (m_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  typedef struct {
    logic        r0_req;
    logic        r0_we;
    logic [31:0] r0_addr;
    logic [31:0] r0_wdata;
    logic        r1_req;
    logic        r1_we;
    logic [31:0] r1_addr;
    logic [31:0] r1_wdata;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        mrd;
    logic        mwr;
    logic [31:0] maddr;
    logic [31:0] mwd;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mk(
    input logic a0, w0, input logic [31:0] ad0, wd0,
    input logic a1, w1, input logic [31:0] ad1, wd1,
    input logic [1:0] g, rv, input logic [31:0] e0, e1,
    input logic mr, mw, input logic [31:0] ma, md);
    vec_t v;
    v.r0_req = a0; v.r0_we = w0; v.r0_addr = ad0; v.r0_wdata = wd0;
    v.r1_req = a1; v.r1_we = w1; v.r1_addr = ad1; v.r1_wdata = wd1;
    v.gnt = g; v.rvalid = rv; v.rd0 = e0; v.rd1 = e1;
    v.mrd = mr; v.mwr = mw; v.maddr = ma; v.mwd = md;
    return v;
  endfunction

  function automatic logic [159:0] obs();
    return {r1_gnt, r0_gnt, r1_rvalid, r0_rvalid, r0_rdata, r1_rdata,
            m_memread, m_memwrite, m_address, m_wdata};
  endfunction

  task automatic chk(input string nm, input logic [159:0] act, exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s act=%h exp=%h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic one_grant(input logic who);
    int c;
    if (who) r1_req = 1'b1;
    else     r0_req = 1'b1;
    c = 0;
    #1;
    while (!(r0_gnt | r1_gnt) && c < 6) begin
      step();
      #1;
      c++;
    end
    chk("stat_gnt_wait", {(r0_gnt | r1_gnt)}, 1'b1);
    step();
    idle_inputs();
    repeat (3) step();
  endtask
`endif

  initial begin
    int ng;
    vec_t v;
    vecs[0]  = mk(0,0,0,0,             0,0,0,0,    2'b00,2'b00,0,0,0,0,0,0);
    vecs[1]  = mk(1,1,32'h08,32'hDEADBEEF, 0,0,0,0, 2'b01,2'b00,0,0,0,0,0,0);
    vecs[2]  = mk(0,0,0,0,             0,0,0,0,    2'b00,2'b00,0,0,0,1,32'h08,32'hDEADBEEF);
    vecs[3]  = mk(0,0,0,0,             0,0,0,0,    2'b00,2'b01,0,0,0,0,0,0);
    vecs[4]  = mk(1,0,32'h08,0,        0,0,0,0,    2'b01,2'b00,0,0,0,0,0,0);
    vecs[5]  = mk(0,0,0,0,             0,0,0,0,    2'b00,2'b00,0,0,1,0,32'h08,0);
    vecs[6]  = mk(1,0,32'h00,0,        1,0,32'h04,0, 2'b10,2'b01,32'hDEADBEEF,0,0,0,0,0);
    vecs[7]  = mk(1,0,32'h00,0,        0,0,0,0,    2'b00,2'b00,32'hDEADBEEF,0,1,0,32'h04,0);
    vecs[8]  = mk(1,0,32'h00,0,        0,0,0,0,    2'b01,2'b10,32'hDEADBEEF,32'h10000001,0,0,0,0);
    vecs[9]  = mk(0,0,0,0,             0,0,0,0,    2'b00,2'b00,32'hDEADBEEF,32'h10000001,1,0,32'h00,0);
    vecs[10] = mk(0,0,0,0,             0,0,0,0,    2'b00,2'b01,32'h10000000,32'h10000001,0,0,0,0);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("idle%0d", i), obs(), '0);
      step();
    end

    for (int i = 0; i < 11; i++) begin
      v = vecs[i];
      r0_req = v.r0_req; r0_we = v.r0_we; r0_addr = v.r0_addr; r0_wdata = v.r0_wdata;
      r1_req = v.r1_req; r1_we = v.r1_we; r1_addr = v.r1_addr; r1_wdata = v.r1_wdata;
      #1 chk($sformatf("vec%0d", i), obs(),
             {v.gnt, v.rvalid, v.rd0, v.rd1, v.mrd, v.mwr, v.maddr, v.mwd});
      step();
    end

    // Both read from reset: r0 first, r1 two cycles later.
    do_reset();
    r0_req = 1; r0_addr = 32'h00; r1_req = 1; r1_addr = 32'h04;
    #1 chk("both_t0", {r1_gnt, r0_gnt}, 2'b01);
    step();
    r0_req = 0;
    #1 chk("both_t1", {r1_gnt, r0_gnt, m_memread, m_address}, {2'b00, 1'b1, 32'h00});
    step();
    #1 chk("both_t2", {r1_gnt, r0_gnt, r0_rvalid, r0_rdata}, {2'b10, 1'b1, 32'h10000000});
    step();
    r1_req = 0;
    #1 chk("both_t3", {m_memread, m_address, r1_rvalid}, {1'b1, 32'h04, 1'b0});
    step();
    #1 chk("both_t4", {r1_rvalid, r1_rdata, r0_rdata}, {1'b1, 32'h10000001, 32'h10000000});
    step();

    // Continuous contention must alternate, r0 first.
    r0_req = 1; r0_addr = 32'h10; r1_req = 1; r1_addr = 32'h14;
    ng = 0;
    for (int c = 0; c < 40 && ng < 8; c++) begin
      #1;
      if (r0_gnt | r1_gnt) begin
        chk($sformatf("alt%0d", ng), {r1_gnt, r0_gnt}, (ng % 2) ? 2'b10 : 2'b01);
        ng++;
      end
      step();
    end
    if (ng < 8) chk("alt_budget", ng, 8);
    idle_inputs();
    repeat (3) step();

    // Reset while an r1 read is in its access cycle.
    do_reset();
    r1_req = 1; r1_addr = 32'h0C;
    #1 chk("rst_gnt1", {r1_gnt, r0_gnt}, 2'b10);
    step();
    reset = 1; r0_req = 1; r1_req = 1;
    #1 chk("rst_mem", {m_memread, m_memwrite, r1_gnt, r0_gnt}, 4'b0000);
    step();
    #1 chk("rst_hold", {r1_rvalid, r1_gnt, r0_gnt}, 3'b000);
    reset = 0;
    #1 chk("rst_ptr", {r1_rvalid, r1_gnt, r0_gnt}, 3'b001);
    step();
    idle_inputs();
    #1 chk("rst_norv", {r1_rvalid, m_memread}, 2'b01);
    repeat (3) step();

`ifdef DMEM_ARB_STATS_EN
    do_reset();
    #1 chk("cnt_reset", {grant_cnt0, grant_cnt1}, 32'h0);
    one_grant(1'b0);
    one_grant(1'b0);
    one_grant(1'b0);
    one_grant(1'b1);
    chk("cnt_vals", {grant_cnt0, grant_cnt1}, {16'd3, 16'd1});
    force dut.grant_cnt0 = 16'hFFFF;
    #1 release dut.grant_cnt0;
    one_grant(1'b0);
    chk("cnt_sat", {grant_cnt0, grant_cnt1}, {16'hFFFF, 16'd1});
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
